// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receiver for the fpga_rx pad.
//
// This block turns 8N1 serial frames into bytes on a valid/ready interface. When the build
// defines UART_RX_PARITY_EN, it accepts 8E1 frames instead. It synchronises the asynchronous
// pin, checks the start bit at mid-bit, and samples every later bit at mid-bit. It flags
// framing errors, overrun and (optionally) parity errors with one-cycle pulses.
//
// Build option:
//   UART_RX_PARITY_EN  frame = start + 8 data + even parity + stop; a parity mismatch drops the
//                      byte and pulses parity_err. Undefined: 8N1 only, parity_err tied to 0.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-low reset
//   rx          asynchronous serial input, idle high
//   rx_data     received byte, stable while rx_valid=1
//   rx_valid    byte available, held until accepted
//   rx_ready    consumer accepts the byte when rx_valid & rx_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while the previous byte was still unaccepted
//   parity_err  one-cycle pulse: parity mismatch (always 0 without the parity option)
//   busy        receiver FSM is not idle
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad_q, parity_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif
  logic                   rxs;
  logic                   complete;

  // Synchroniser shifts towards the MSB; the last stage is the only one the FSM looks at.
  assign rxs    = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // A start bit that is high again at mid-bit was a glitch: drop it silently.
        if (cnt_q == HalfCnt) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d        = '0;
          // Even parity: the parity bit equals the XOR of the data bits.
          parity_bad_d = rxs ^ (^shift_q);
          state_d      = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              complete = 1'b1;
            end
`else
            complete = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Stay here while the line is held low so a break is not taken as a new start bit.
        cnt_d = '0;
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // A completed byte is taken only if the holding register is free or is being drained now.
    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
